// File: rtl/turbo_dec_pkg.sv
// Shared turbo-decoder types and constants.
// Reliability magnitudes are unsigned MAG_W-bit values; MAG_MAX is the neutral element for min.
package turbo_dec_pkg;

  localparam int unsigned LLR_W = 31;
  localparam int unsigned MAG_W = 30;
  localparam int unsigned NIB_W = 4;

  typedef logic [MAG_W-1:0] mag_t;

  localparam mag_t MAG_MAX = 30'h3FFFFFFF;

  function automatic mag_t mag_min(input mag_t a, input mag_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO. A push into a full FIFO is accepted only when
// it coincides with a pop; otherwise it is dropped and flagged on push_drop.
module byte_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             push_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop);
    push_drop = push & full & ~pop;
    // Gate the head so an empty FIFO always presents zero.
    dout      = empty ? '0 : mem_q[rd_ptr_q];

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dec_bit_pack.sv
// Turbo-decoder output packer: nibbles to bytes behind a FIFO, frame delimiting
// and per-frame minimum reliability for the iteration controller.
module dec_bit_pack
  import turbo_dec_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter mag_t        CONF_TH    = 30'd4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [NIB_W-1:0] d,
  input  mag_t             how_1,
  input  mag_t             how_2,
  input  mag_t             how_3,
  input  mag_t             how_4,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frame_done,
  output mag_t             min_how,
  output logic             low_conf,
  output logic             overflow
);

  localparam int unsigned       CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_BITS - 4);

  logic             ph_q, ph_d;
  logic [3:0]       lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mag_t             run_min_q, run_min_d;
  mag_t             min_how_q, min_how_d;
  logic             low_conf_q, low_conf_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;

  mag_t             tree_min, frame_min;
  logic             is_last;
  logic             push, pop, push_drop, fifo_empty, fifo_full;
  logic [8:0]       fifo_din, fifo_dout;

  always_comb begin
    tree_min  = mag_min(mag_min(how_1, how_2), mag_min(how_3, how_4));
    frame_min = mag_min(run_min_q, tree_min);
    is_last   = (cnt_q == LAST_CNT);
    fifo_din  = {is_last, d, lo_q};

    ph_d         = ph_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    run_min_d    = run_min_q;
    min_how_d    = min_how_q;
    low_conf_d   = low_conf_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | push_drop;
    push         = 1'b0;

    if (in_valid) begin
      ph_d      = ~ph_q;
      run_min_d = frame_min;
      if (!ph_q) lo_d = d;
      else       push = 1'b1;
      cnt_d = is_last ? '0 : cnt_q + CNT_W'(4);
      // Last nibble always lands in ph=1 since FRAME_BITS is a multiple of 8.
      if (is_last) begin
        frame_done_d = 1'b1;
        min_how_d    = frame_min;
        low_conf_d   = (frame_min < CONF_TH);
        run_min_d    = MAG_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ph_q         <= 1'b0;
      lo_q         <= '0;
      cnt_q        <= '0;
      run_min_q    <= MAG_MAX;
      min_how_q    <= '0;
      low_conf_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      ph_q         <= ph_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      run_min_q    <= run_min_d;
      min_how_q    <= min_how_d;
      low_conf_q   <= low_conf_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pop = out_valid & out_ready;

  byte_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (fifo_din),
    .pop       (pop),
    .dout      (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .push_drop (push_drop)
  );

  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_dout[7:0];
  assign out_last   = fifo_dout[8];
  assign frame_done = frame_done_q;
  assign min_how    = min_how_q;
  assign low_conf   = low_conf_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dec_bit_pack.sv
// Scoreboard bench for dec_bit_pack with FRAME_BITS=16, FIFO_DEPTH=4.
// Expected bytes and frame results are queued at stimulus time and checked by a monitor.
module tb_dec_bit_pack;
  import turbo_dec_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] d;
  mag_t       how_1, how_2, how_3, how_4;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last, frame_done, low_conf, overflow;
  mag_t       min_how;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int fd_count = 0;

  logic [8:0]  exp_q [$];
  logic [30:0] min_q [$];

  always #5 clk = ~clk;

  dec_bit_pack #(
    .FRAME_BITS (16),
    .FIFO_DEPTH (4),
    .CONF_TH    (30'd4096)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .d          (d),
    .how_1      (how_1),
    .how_2      (how_2),
    .how_3      (how_3),
    .how_4      (how_4),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .min_how    (min_how),
    .low_conf   (low_conf),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted head byte and every frame_done pulse.
  always @(negedge clk) begin
    logic [8:0]  eb;
    logic [30:0] em;
    if (rst === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_byte: got %0h expected none", {out_last, out_data});
      end else begin
        eb = exp_q.pop_front();
        check("byte", {23'd0, out_last, out_data}, {23'd0, eb});
      end
    end
    if (rst === 1'b1 && frame_done) begin
      fd_count++;
      if (min_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_frame_done: got min %0d expected none", min_how);
      end else begin
        em = min_q.pop_front();
        check("min_how/low_conf", {1'b0, low_conf, min_how}, {1'b0, em});
      end
    end
  end

  task automatic send(input logic [3:0] n, input mag_t h1, input mag_t h2,
                      input mag_t h3, input mag_t h4);
    in_valid = 1'b1;
    d        = n;
    how_1    = h1;
    how_2    = h2;
    how_3    = h3;
    how_4    = h4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || min_q.size() != 0 || out_valid) && n < 100) begin
      idle(1);
      n++;
    end
    check({name, "_drained"}, exp_q.size() + min_q.size() + 32'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d = '0;
    how_1 = '0; how_2 = '0; how_3 = '0; how_4 = '0;
    do_reset();

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data_last", {out_last, out_data}, 0);
    check("rst_fd_min_lc_ovf", {frame_done, low_conf, overflow, min_how}, 0);

    // 1: basic frame
    exp_q.push_back(9'h05A); exp_q.push_back(9'h1C3); min_q.push_back({1'b1, 30'd100});
    send(4'hA, 100, 100, 100, 100);
    send(4'h5, 100, 100, 100, 100);
    send(4'h3, 100, 100, 100, 100);
    send(4'hC, 100, 100, 100, 100);
    check("fd_pulse_high", frame_done, 1);
    idle(1);
    check("fd_pulse_low", frame_done, 0);
    drain("basic");

    // 2: minimum tracking and run_min reload
    exp_q.push_back(9'h021); exp_q.push_back(9'h143); min_q.push_back({1'b0, 30'd5000});
    send(4'h1, 8000, 8000, 8000, 8000);
    send(4'h2, 8000, 8000, 5000, 8000);
    send(4'h3, 8000, 8000, 8000, 8000);
    send(4'h4, 8000, 8000, 8000, 8000);
    exp_q.push_back(9'h076); exp_q.push_back(9'h198); min_q.push_back({1'b0, 30'd9000});
    send(4'h6, 9000, 9000, 9000, 9000);
    send(4'h7, 9000, 9000, 9000, 9000);
    send(4'h8, 9000, 9000, 9000, 9000);
    send(4'h9, 9000, 9000, 9000, 9000);
    drain("min");

    // 3: backpressure and overflow; only the first 4 bytes survive
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 2) begin
        exp_q.push_back({1'b0, 4'(k + 1), 4'(k)});
        exp_q.push_back({1'b1, 4'(k + 3), 4'(k + 2)});
      end
      min_q.push_back({1'b1, 30'd200});
      for (int j = 0; j < 4; j++) begin
        send(4'(k + j), 200, 200, 200, 200);
        if (k == 1 && j == 3) check("ovf_after_4_bytes", overflow, 0);
        if (k == 2 && j == 1) check("ovf_after_5th_byte", overflow, 1);
      end
    end
    check("held_head", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h10});
    out_ready = 1'b1;
    drain("backpressure");
    check("ovf_sticky", overflow, 1);

    do_reset();
    check("rst2_ovf", overflow, 0);
    check("rst2_min_lc", {low_conf, min_how}, 0);

    // 4: full FIFO with simultaneous pop
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, 4'(k + 1), 4'(k)});
      exp_q.push_back({1'b1, 4'(k + 3), 4'(k + 2)});
      min_q.push_back({1'b1, 30'd300});
      for (int j = 0; j < 4; j++) send(4'(k + j), 300, 300, 300, 300);
    end
    exp_q.push_back(9'h032); exp_q.push_back(9'h154); min_q.push_back({1'b1, 30'd300});
    send(4'h2, 300, 300, 300, 300);
    out_ready = 1'b1;
    send(4'h3, 300, 300, 300, 300);
    check("ovf_push_pop", overflow, 0);
    send(4'h4, 300, 300, 300, 300);
    send(4'h5, 300, 300, 300, 300);
    drain("full_pop");
    check("ovf_after_full_pop", overflow, 0);

    // 5a: gaps between nibbles
    exp_q.push_back(9'h05A); exp_q.push_back(9'h1C3); min_q.push_back({1'b1, 30'd100});
    send(4'hA, 100, 100, 100, 100); idle(3);
    send(4'h5, 100, 100, 100, 100); idle(3);
    send(4'h3, 100, 100, 100, 100); idle(3);
    send(4'hC, 100, 100, 100, 100);
    drain("gaps");

    // 5b: reset mid-frame discards the partial frame and its completed byte
    out_ready = 1'b0;
    send(4'h1, 50, 50, 50, 50);
    send(4'h2, 50, 50, 50, 50);
    send(4'h3, 50, 50, 50, 50);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    fd_count = 0;
    check("midrst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    exp_q.push_back(9'h0FE); exp_q.push_back(9'h110); min_q.push_back({1'b0, 30'd7000});
    send(4'hE, 7000, 7000, 7000, 7000);
    send(4'hF, 7000, 7000, 7000, 7000);
    send(4'h0, 7000, 7000, 7000, 7000);
    send(4'h1, 7000, 7000, 7000, 7000);
    drain("midrst");
    check("midrst_fd_count", fd_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
